// File: rtl/uart_arb_pkg.sv
// ============================================================================
// Module  : uart_arb_pkg
// Brief   : Shared types and sizing helpers for the uart_tx arbiter.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package uart_arb_pkg;

  localparam int DEFAULT_NUM_REQ      = 4;
  localparam int DEFAULT_EN_HOLD      = 3;
  localparam int DEFAULT_GAP_CYCLES   = 32;
  localparam int DEFAULT_BUSY_TIMEOUT = 16;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LAUNCH    = 3'd1,
    WAIT_BUSY = 3'd2,
    WAIT_DONE = 3'd3,
    GAP       = 3'd4
  } arb_state_t;

  // One counter serves every timed phase, so it must hold the largest count.
  function automatic int cnt_width(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return $clog2(m + 1);
  endfunction

  localparam int DEFAULT_CNT_W =
    cnt_width(DEFAULT_EN_HOLD, DEFAULT_GAP_CYCLES, DEFAULT_BUSY_TIMEOUT);

endpackage

`default_nettype wire

// File: rtl/rr_pick.sv
// ============================================================================
// Module  : rr_pick
// Brief   : Combinational one-hot round-robin selector starting at i_ptr.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_pick
  import uart_arb_pkg::*;
#(
  parameter int NUM_REQ = DEFAULT_NUM_REQ,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IDX_W-1:0]   i_ptr,
  output logic [NUM_REQ-1:0] o_onehot,
  output logic [IDX_W-1:0]   o_idx,
  output logic               o_any
);

  logic [IDX_W-1:0] w_j;

  always_comb begin
    o_onehot = '0;
    o_idx    = '0;
    o_any    = 1'b0;
    w_j      = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_j = IDX_W'((int'(i_ptr) + k) % NUM_REQ);
      if (!o_any && i_req[w_j]) begin
        o_any         = 1'b1;
        o_onehot[w_j] = 1'b1;
        o_idx         = w_j;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
// ============================================================================
// Module  : uart_tx_arbiter
// Brief   : Round-robin sharing of one uart_tx among NUM_REQ byte producers.
//           Optional busy timeout enabled by macro UART_ARB_TIMEOUT_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int NUM_REQ      = DEFAULT_NUM_REQ,
  parameter int EN_HOLD      = DEFAULT_EN_HOLD,
  parameter int GAP_CYCLES   = DEFAULT_GAP_CYCLES,
  parameter int BUSY_TIMEOUT = DEFAULT_BUSY_TIMEOUT
) (
  input  logic                 clk,
  input  logic                 uart_rst_n,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [NUM_REQ*8-1:0] req_data,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic [NUM_REQ-1:0]   grant,
  output logic                 uart_en,
  output logic [7:0]           tx_data,
  input  logic                 tx_state,
  output logic                 busy,
  output logic                 err_timeout
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = cnt_width(EN_HOLD, GAP_CYCLES, BUSY_TIMEOUT);

  localparam logic [IDX_W-1:0] C_IDX_LAST = IDX_W'(NUM_REQ - 1);
  localparam logic [CNT_W-1:0] C_EN_LAST  = CNT_W'(EN_HOLD - 1);
  localparam logic [CNT_W-1:0] C_GAP_LAST = CNT_W'(GAP_CYCLES - 1);

  arb_state_t         r_state;
  logic [IDX_W-1:0]   r_ptr;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_seen;

  logic [NUM_REQ-1:0] w_win;
  logic [IDX_W-1:0]   w_idx;
  logic               w_any;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_pick (
    .i_req    (req_valid),
    .i_ptr    (r_ptr),
    .o_onehot (w_win),
    .o_idx    (w_idx),
    .o_any    (w_any)
  );

`ifdef UART_ARB_TIMEOUT_EN
  localparam logic [CNT_W-1:0] C_TO_LAST = CNT_W'(BUSY_TIMEOUT - 1);
  logic [CNT_W-1:0] r_to_cnt;
  logic             w_to_hit;

  assign w_to_hit = (r_state == LAUNCH || r_state == WAIT_BUSY) &&
                    !tx_state && !r_seen && (r_to_cnt == C_TO_LAST);

  always_ff @(posedge clk or negedge uart_rst_n) begin
    if (!uart_rst_n) begin
      r_to_cnt    <= '0;
      err_timeout <= 1'b0;
    end else begin
      err_timeout <= w_to_hit;
      if (r_state == IDLE)
        r_to_cnt <= '0;
      else if (r_state == LAUNCH || r_state == WAIT_BUSY)
        r_to_cnt <= r_to_cnt + 1'b1;
    end
  end
`else
  logic w_to_hit;
  assign w_to_hit    = 1'b0;
  assign err_timeout = 1'b0;
`endif

  always_ff @(posedge clk or negedge uart_rst_n) begin
    if (!uart_rst_n) begin
      r_state   <= IDLE;
      r_ptr     <= '0;
      r_cnt     <= '0;
      r_seen    <= 1'b0;
      req_ready <= '0;
      grant     <= '0;
      uart_en   <= 1'b0;
      tx_data   <= 8'h00;
      busy      <= 1'b0;
    end else begin
      req_ready <= '0;
      if (w_to_hit) begin
        // Byte is dropped; the pointer already moved past its owner.
        grant   <= '0;
        uart_en <= 1'b0;
        busy    <= 1'b0;
        r_state <= IDLE;
      end else begin
        case (r_state)
          IDLE: begin
            // A stray transfer on the line blocks launching until it ends.
            if (w_any && !tx_state) begin
              tx_data   <= req_data[w_idx*8 +: 8];
              grant     <= w_win;
              req_ready <= w_win;
              r_ptr     <= (w_idx == C_IDX_LAST) ? '0 : w_idx + 1'b1;
              uart_en   <= 1'b1;
              busy      <= 1'b1;
              r_cnt     <= '0;
              r_seen    <= 1'b0;
              r_state   <= LAUNCH;
            end
          end
          LAUNCH: begin
            if (tx_state) r_seen <= 1'b1;
            if (r_cnt == C_EN_LAST) begin
              uart_en <= 1'b0;
              r_state <= (r_seen || tx_state) ? WAIT_DONE : WAIT_BUSY;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
          WAIT_BUSY: begin
            if (tx_state) r_state <= WAIT_DONE;
          end
          WAIT_DONE: begin
            if (!tx_state) begin
              r_cnt   <= '0;
              r_state <= GAP;
            end
          end
          GAP: begin
            if (r_cnt == C_GAP_LAST) begin
              grant   <= '0;
              busy    <= 1'b0;
              r_state <= IDLE;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
// ============================================================================
// Module  : tb_uart_tx_arbiter
// Brief   : Self-checking bench with a uart_tx model and serial receiver.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_tx_arbiter;

  localparam int NUM_REQ = 4;
  localparam int BIT     = 20;

  logic        clk = 1'b0;
  logic        uart_rst_n = 1'b0;
  logic [3:0]  req_valid = '0;
  logic [31:0] req_data = '0;
  logic [3:0]  req_ready, grant;
  logic        uart_en, busy, err_timeout, tx_state;
  logic [7:0]  tx_data;

  always #5 clk = ~clk;

  uart_tx_arbiter #(.NUM_REQ(NUM_REQ)) dut (
    .clk(clk), .uart_rst_n(uart_rst_n), .req_valid(req_valid),
    .req_data(req_data), .req_ready(req_ready), .grant(grant),
    .uart_en(uart_en), .tx_data(tx_data), .tx_state(tx_state),
    .busy(busy), .err_timeout(err_timeout)
  );

  // uart_tx model: two-flop synchroniser, edge start, LSB-first frame.
  logic       m_busy = 1'b0, mute = 1'b0, stray = 1'b0;
  logic       e1 = 1'b0, e2 = 1'b0, e3 = 1'b0;
  logic [9:0] sh = 10'h3ff;
  int         bc = 0, nb = 0;
  logic       txd;
  assign tx_state = m_busy | stray;
  assign txd      = m_busy ? sh[0] : 1'b1;

  always @(posedge clk) begin
    e1 <= uart_en; e2 <= e1; e3 <= e2;
    if (!m_busy) begin
      if (e2 && !e3 && !mute) begin
        m_busy <= 1'b1; sh <= {1'b1, tx_data, 1'b0}; bc <= 0; nb <= 0;
      end
    end else if (bc == BIT - 1) begin
      bc <= 0; sh <= {1'b1, sh[9:1]}; nb <= nb + 1;
      if (nb == 9) m_busy <= 1'b0;
    end else begin
      bc <= bc + 1;
    end
  end

  logic [7:0] rx_q[$];
  bit         rx_frm_q[$];
  initial begin
    forever begin
      @(negedge clk);
      if (txd === 1'b0) begin
        logic [7:0] b;
        logic       st;
        repeat (BIT / 2) @(negedge clk);
        st = txd;
        for (int i = 0; i < 8; i++) begin
          repeat (BIT) @(negedge clk);
          b[i] = txd;
        end
        repeat (BIT) @(negedge clk);
        rx_frm_q.push_back(!st && txd);
        rx_q.push_back(b);
      end
    end
  end

  logic [3:0] ready_q[$], grant_q[$];
  int  ready_cnt = 0;
  bit  err_seen = 0;
  bit  gap_en = 0;
  int  since = -1, min_gap = 1000000;
  logic ts_p = 1'b0, en_p = 1'b0;
  always @(negedge clk) begin
    if (req_ready !== 4'b0) begin
      ready_q.push_back(req_ready); grant_q.push_back(grant); ready_cnt++;
    end
    if (err_timeout === 1'b1) err_seen = 1;
    if (!gap_en) since = -1;
    else if (ts_p && !m_busy) since = 0;
    else if (since >= 0) since++;
    if (gap_en && uart_en && !en_p && since >= 0 && since < min_gap) min_gap = since;
    ts_p = m_busy; en_p = uart_en;
  end

  int n_cmp = 0, n_bad = 0;
  int exp_idx_q[$];
  logic [7:0] exp_byte_q[$];

  task automatic wait_ready(output logic [3:0] r, output logic [3:0] g, output bit ok);
    ok = 0; r = '0; g = '0;
    for (int t = 0; t < 3000 && !ok; t++) begin
      @(negedge clk); #1;
      if (ready_q.size() > 0) begin
        r = ready_q.pop_front(); g = grant_q.pop_front(); ok = 1;
      end
    end
  endtask

  task automatic wait_rx(output logic [7:0] b, output bit frm, output bit ok);
    ok = 0; b = '0; frm = 0;
    for (int t = 0; t < 5000 && !ok; t++) begin
      @(negedge clk); #1;
      if (rx_q.size() > 0) begin
        b = rx_q.pop_front(); frm = rx_frm_q.pop_front(); ok = 1;
      end
    end
  endtask

  task automatic wait_idle(output bit ok);
    ok = 0;
    for (int t = 0; t < 8000 && !ok; t++) begin
      @(negedge clk);
      if (busy === 1'b0 && !m_busy) ok = 1;
    end
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clk);
    n_cmp++; if (req_ready !== 4'b0) begin n_bad++; $display("FAIL reset_ready got %b want 0000", req_ready); end
    n_cmp++; if (grant !== 4'b0) begin n_bad++; $display("FAIL reset_grant got %b want 0000", grant); end
    n_cmp++; if (uart_en !== 1'b0) begin n_bad++; $display("FAIL reset_en got %b want 0", uart_en); end
    n_cmp++; if (tx_data !== 8'h00) begin n_bad++; $display("FAIL reset_data got %h want 00", tx_data); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %b want 0", busy); end
    n_cmp++; if (err_timeout !== 1'b0) begin n_bad++; $display("FAIL reset_err got %b want 0", err_timeout); end
    uart_rst_n = 1'b1;
  endtask

  task automatic test_single;
    int n, m, t;
    logic [7:0] b; bit frm, ok;
    req_data = 32'h0000_A500; req_valid = 4'b0010;
    t = 0;
    do begin @(negedge clk); t++; end while (req_ready === 4'b0 && t < 100);
    n_cmp++; if (req_ready !== 4'b0010) begin n_bad++; $display("FAIL single_ready got %b want 0010", req_ready); end
    n_cmp++; if (grant !== 4'b0010) begin n_bad++; $display("FAIL single_grant got %b want 0010", grant); end
    n_cmp++; if (tx_data !== 8'hA5) begin n_bad++; $display("FAIL single_data got %h want a5", tx_data); end
    req_valid = 4'b0;
    n = 1;
    @(negedge clk);
    n_cmp++; if (req_ready !== 4'b0) begin n_bad++; $display("FAIL single_ready_pulse got %b want 0000", req_ready); end
    while (uart_en === 1'b1 && n < 20) begin n++; @(negedge clk); end
    n_cmp++; if (n !== 3) begin n_bad++; $display("FAIL single_en_len got %0d want 3", n); end
    t = 0;
    while (tx_state !== 1'b1 && t < 100) begin @(negedge clk); t++; end
    n_cmp++; if (tx_state !== 1'b1) begin n_bad++; $display("FAIL single_txstate got %b want 1", tx_state); end
    t = 0;
    while (tx_state === 1'b1 && t < 1000) begin @(negedge clk); t++; end
    m = 0;
    while (busy === 1'b1 && m < 100) begin @(negedge clk); m++; end
    n_cmp++; if (m !== 33) begin n_bad++; $display("FAIL single_busy_tail got %0d want 33", m); end
    wait_rx(b, frm, ok);
    n_cmp++; if (!ok || b !== 8'hA5 || !frm) begin n_bad++; $display("FAIL single_serial got %h frm %0d ok %0d want a5 1 1", b, frm, ok); end
    ready_q.delete(); grant_q.delete();
  endtask

  task automatic test_all_four;
    logic [3:0] r, g; logic [7:0] b; bit ok, frm;
    int base, e;
    wait_idle(ok);
    @(negedge clk); uart_rst_n = 1'b0; @(negedge clk); uart_rst_n = 1'b1;
    ready_q.delete(); grant_q.delete(); rx_q.delete(); rx_frm_q.delete();
    base = ready_cnt; gap_en = 1; min_gap = 1000000;
    foreach (exp_idx_q[i]) exp_idx_q.delete(i);
    exp_idx_q = '{0, 1, 2, 3, 0};
    exp_byte_q = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h10};
    req_data = 32'h1312_1110; req_valid = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      wait_ready(r, g, ok);
      if (k == 4) req_valid = 4'b0;
      e = exp_idx_q.pop_front();
      n_cmp++; if (!ok || r !== (4'b1 << e)) begin n_bad++; $display("FAIL rr_ready[%0d] got %b want %b", k, r, 4'b1 << e); end
      n_cmp++; if (g !== (4'b1 << e)) begin n_bad++; $display("FAIL rr_grant[%0d] got %b want %b", k, g, 4'b1 << e); end
    end
    for (int k = 0; k < 5; k++) begin
      wait_rx(b, frm, ok);
      n_cmp++; if (!ok || !frm || b !== exp_byte_q[0]) begin n_bad++; $display("FAIL rr_serial[%0d] got %h want %h", k, b, exp_byte_q[0]); end
      void'(exp_byte_q.pop_front());
    end
    wait_idle(ok);
    gap_en = 0;
    n_cmp++; if (ready_cnt - base !== 5) begin n_bad++; $display("FAIL rr_ready_count got %0d want 5", ready_cnt - base); end
    n_cmp++; if (min_gap < 33) begin n_bad++; $display("FAIL gap got %0d want >=33", min_gap); end
  endtask

  task automatic test_wrap;
    logic [3:0] r, g; logic [7:0] b; bit ok, frm;
    int e;
    exp_idx_q = '{2, 3, 0, 0};
    exp_byte_q = '{8'h82, 8'h83, 8'h80, 8'h80};
    req_data = 32'h8382_8180;
    req_valid = 4'b0100;
    wait_ready(r, g, ok); req_valid = 4'b0;
    e = exp_idx_q.pop_front();
    n_cmp++; if (!ok || r !== (4'b1 << e)) begin n_bad++; $display("FAIL wrap_a got %b want %b", r, 4'b1 << e); end
    wait_idle(ok);
    req_valid = 4'b1001;
    for (int k = 0; k < 2; k++) begin
      wait_ready(r, g, ok);
      if (k == 1) req_valid = 4'b0;
      e = exp_idx_q.pop_front();
      n_cmp++; if (!ok || r !== (4'b1 << e)) begin n_bad++; $display("FAIL wrap_b[%0d] got %b want %b", k, r, 4'b1 << e); end
    end
    wait_idle(ok);
    req_valid = 4'b0001;
    wait_ready(r, g, ok); req_valid = 4'b0;
    e = exp_idx_q.pop_front();
    n_cmp++; if (!ok || r !== (4'b1 << e)) begin n_bad++; $display("FAIL wrap_c got %b want %b", r, 4'b1 << e); end
    for (int k = 0; k < 4; k++) begin
      wait_rx(b, frm, ok);
      n_cmp++; if (!ok || !frm || b !== exp_byte_q[0]) begin n_bad++; $display("FAIL wrap_serial[%0d] got %h want %h", k, b, exp_byte_q[0]); end
      void'(exp_byte_q.pop_front());
    end
    wait_idle(ok);
  endtask

  task automatic test_stray;
    logic [3:0] r, g; logic [7:0] b; bit ok, frm;
    stray = 1'b1; req_data = 32'h0000_005A; req_valid = 4'b0001;
    ready_q.delete(); grant_q.delete();
    repeat (20) @(negedge clk);
    n_cmp++; if (ready_q.size() !== 0 || uart_en !== 1'b0) begin n_bad++; $display("FAIL stray_hold got ready %0d en %b want 0 0", ready_q.size(), uart_en); end
    stray = 1'b0;
    wait_ready(r, g, ok); req_valid = 4'b0;
    n_cmp++; if (!ok || r !== 4'b0001) begin n_bad++; $display("FAIL stray_grant got %b want 0001", r); end
    wait_rx(b, frm, ok);
    n_cmp++; if (!ok || !frm || b !== 8'h5A) begin n_bad++; $display("FAIL stray_serial got %h want 5a", b); end
    wait_idle(ok);
  endtask

`ifdef UART_ARB_TIMEOUT_EN
  task automatic test_timeout;
    logic [3:0] r, g; logic [7:0] b; bit ok, frm;
    int k, t;
    mute = 1'b1; req_data = 32'h00C2_C100; req_valid = 4'b0110;
    t = 0;
    do begin @(negedge clk); t++; end while (req_ready === 4'b0 && t < 100);
    n_cmp++; if (req_ready !== 4'b0010) begin n_bad++; $display("FAIL to_first got %b want 0010", req_ready); end
    k = 0;
    do begin @(negedge clk); k++; end while (err_timeout !== 1'b1 && k < 100);
    n_cmp++; if (k !== 16) begin n_bad++; $display("FAIL to_delay got %0d want 16", k); end
    n_cmp++; if (busy !== 1'b0 || grant !== 4'b0 || uart_en !== 1'b0) begin n_bad++; $display("FAIL to_idle got busy %b grant %b en %b want 0", busy, grant, uart_en); end
    req_valid = 4'b0100; mute = 1'b0;
    ready_q.delete(); grant_q.delete();
    @(negedge clk);
    n_cmp++; if (err_timeout !== 1'b0) begin n_bad++; $display("FAIL to_pulse got %b want 0", err_timeout); end
    wait_ready(r, g, ok); req_valid = 4'b0;
    n_cmp++; if (!ok || r !== 4'b0100) begin n_bad++; $display("FAIL to_next got %b want 0100", r); end
    wait_rx(b, frm, ok);
    n_cmp++; if (!ok || !frm || b !== 8'hC2) begin n_bad++; $display("FAIL to_serial got %h want c2", b); end
    wait_idle(ok);
  endtask
`else
  task automatic test_timeout;
    n_cmp++; if (err_seen !== 1'b0) begin n_bad++; $display("FAIL err_tied got %0d want 0", err_seen); end
  endtask
`endif

  task automatic test_reset_mid;
    logic [3:0] r, g; bit ok;
    int t;
    req_data = 32'h00C3_00E7; req_valid = 4'b0100;
    wait_ready(r, g, ok); req_valid = 4'b0;
    t = 0;
    while (!(uart_en === 1'b0 && tx_state === 1'b1) && t < 200) begin @(negedge clk); t++; end
    @(negedge clk);
    uart_rst_n = 1'b0; #1;
    n_cmp++; if (uart_en !== 1'b0 || grant !== 4'b0 || busy !== 1'b0 || tx_data !== 8'h00) begin
      n_bad++; $display("FAIL mid_reset got en %b grant %b busy %b data %h want 0", uart_en, grant, busy, tx_data); end
    req_valid = 4'b0101;
    repeat (3) @(negedge clk);
    uart_rst_n = 1'b1;
    ready_q.delete(); grant_q.delete(); rx_q.delete(); rx_frm_q.delete();
    wait_ready(r, g, ok); req_valid = 4'b0;
    n_cmp++; if (!ok || r !== 4'b0001) begin n_bad++; $display("FAIL mid_first got %b want 0001", r); end
    wait_idle(ok);
    n_cmp++; if (rx_q.size() == 0 || rx_q[rx_q.size()-1] !== 8'hE7) begin n_bad++; $display("FAIL mid_serial got %0d bytes want last e7", rx_q.size()); end
  endtask

  initial begin
    test_reset;
    test_single;
    test_all_four;
    test_wrap;
    test_stray;
    test_timeout;
    test_reset_mid;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
